// File: rtl/rng_pkg.sv
// Shared definitions for the RNG sample FIFO: sampler state encoding,
// default sizes and a saturating counter helper.
package rng_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } smp_state_e;

    localparam int RNG_WIDTH      = 32;
    localparam int RNG_FIFO_DEPTH = 8;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/rng_sync_fifo.sv
// Synchronous FIFO with valid/ready read side, occupancy count and a
// sticky overflow flag for pushes that find the FIFO full with no pop.
module rng_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             full, pop, wr;

    assign full     = (count == CW'(DEPTH));
    assign rd_valid = (count != '0);
    assign pop      = rd_valid && rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr       = push && (!full || pop);
    // Storage is not cleared on reset; gate the head so it reads 0 when empty.
    assign rd_data  = rd_valid ? mem[rptr] : '0;

    always_ff @(posedge clk) begin
        if (wr)
            mem[wptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && full && !pop)
                overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/rng_sample_fifo.sv
// Samples a free-running LFSR word into a FIFO with decimation.
// Optional period detection is built when RNG_PERIOD_DETECT_EN is defined.
module rng_sample_fifo
    import rng_pkg::*;
#(
    parameter int WIDTH = RNG_WIDTH,
    parameter int DEPTH = RNG_FIFO_DEPTH,
    parameter int DECIM = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [WIDTH-1:0]           lfsr_q,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       period_flag,
    output logic [31:0]                period_len
);
    localparam logic [7:0] DECIM_LAST = 8'(DECIM - 1);

    smp_state_e state, state_nx;
    logic [7:0] dcnt;
    logic       push_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // ARM burns the cycle carrying the LFSR reset value before RUN samples.
    always_comb begin
        state_nx = state;
        push_req = 1'b0;
        if (!en) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    state_nx = ARM;
                ARM:     state_nx = RUN;
                RUN:     push_req = (dcnt == DECIM_LAST);
                default: state_nx = IDLE;
            endcase
        end
    end

    // Held at 0 outside RUN, so entering RUN always starts a fresh count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            dcnt <= '0;
        else if (state == RUN && en)
            dcnt <= (dcnt == DECIM_LAST) ? 8'd0 : dcnt + 8'd1;
        else
            dcnt <= '0;
    end

    rng_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push_req),
        .wr_data  (lfsr_q),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (count),
        .overflow (overflow)
    );

`ifdef RNG_PERIOD_DETECT_EN
    logic [WIDTH-1:0] ref_val;
    logic             ref_vld;
    logic [31:0]      pcnt, pcnt_inc;

    assign pcnt_inc = sat_inc(pcnt);

    // Counts push requests (dropped ones too) after the reference sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ref_val     <= '0;
            ref_vld     <= 1'b0;
            pcnt        <= '0;
            period_flag <= 1'b0;
            period_len  <= '0;
        end else if (push_req) begin
            if (!ref_vld) begin
                ref_val <= lfsr_q;
                ref_vld <= 1'b1;
                pcnt    <= '0;
            end else begin
                pcnt <= pcnt_inc;
                if (!period_flag && lfsr_q == ref_val) begin
                    period_flag <= 1'b1;
                    period_len  <= pcnt_inc;
                end
            end
        end
    end
`else
    assign period_flag = 1'b0;
    assign period_len  = '0;
`endif

endmodule

// File: tb/tb_rng_sample_fifo.sv
// Scoreboard bench for rng_sample_fifo driven by a 4-bit maximal LFSR.
// Checks period detection when RNG_PERIOD_DETECT_EN is defined.
module tb_rng_sample_fifo;
    localparam int W  = 32;
    localparam int D  = 8;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          rd_ready = 1'b0;
    logic [3:0]    lfsr;
    logic [W-1:0]  lfsr_q;

    logic          rd_valid, overflow, period_flag;
    logic [W-1:0]  rd_data;
    logic [CW-1:0] count;
    logic [31:0]   period_len;

    logic          rd_valid3, overflow3, period_flag3;
    logic [W-1:0]  rd_data3;
    logic [CW-1:0] count3;
    logic [31:0]   period_len3;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: mq tracks occupancy, sb is the scoreboard popped by the monitor.
    logic [W-1:0] mq[$];
    logic [W-1:0] sb[$];
    logic [W-1:0] q3[$];
    int           streak;
    logic         m_ovf, m_ovf3;
    logic         p_ref_vld, p_flag;
    logic [W-1:0] p_ref;
    logic [31:0]  p_cnt, p_len;

    assign lfsr_q = {28'd0, lfsr};

    always #5 clk = ~clk;

    // Upstream x^4+x^3+1 LFSR, seed 1, period 15.
    always @(posedge clk or posedge reset) begin
        if (reset) lfsr <= 4'd1;
        else       lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    end

    rng_sample_fifo #(.WIDTH(W), .DEPTH(D), .DECIM(1)) dut (
        .clk(clk), .reset(reset), .en(en), .lfsr_q(lfsr_q),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .count(count), .overflow(overflow),
        .period_flag(period_flag), .period_len(period_len)
    );

    rng_sample_fifo #(.WIDTH(W), .DEPTH(D), .DECIM(3)) dut3 (
        .clk(clk), .reset(reset), .en(en), .lfsr_q(lfsr_q),
        .rd_valid(rd_valid3), .rd_ready(1'b0), .rd_data(rd_data3),
        .count(count3), .overflow(overflow3),
        .period_flag(period_flag3), .period_len(period_len3)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: en held for k edges means edge 1 arms, edge 2 is
    // discarded, and edges 3.. are RUN cycles, one request per DECIM of them.
    initial begin : model
        bit pop, req, req3;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mq.delete(); sb.delete(); q3.delete();
                streak = 0; m_ovf = 0; m_ovf3 = 0;
                p_ref_vld = 0; p_flag = 0; p_ref = '0; p_cnt = 0; p_len = 0;
            end else begin
                streak = en ? streak + 1 : 0;
                pop  = (mq.size() > 0) && rd_ready;
                req  = en && streak >= 3;
                req3 = en && streak >= 3 && ((streak - 3) % 3) == 2;
                if (pop) void'(mq.pop_front());
                if (req) begin
                    if (mq.size() < D) begin
                        mq.push_back(lfsr_q);
                        sb.push_back(lfsr_q);
                    end else m_ovf = 1;
                end
                if (req3) begin
                    if (q3.size() < D) q3.push_back(lfsr_q);
                    else m_ovf3 = 1;
                end
`ifdef RNG_PERIOD_DETECT_EN
                if (req) begin
                    if (!p_ref_vld) begin
                        p_ref_vld = 1; p_ref = lfsr_q; p_cnt = 0;
                    end else begin
                        if (p_cnt != 32'hFFFF_FFFF) p_cnt++;
                        if (!p_flag && lfsr_q == p_ref) begin
                            p_flag = 1; p_len = p_cnt;
                        end
                    end
                end
`endif
            end
        end
    end

    // Monitor: compare presented outputs on the falling edge, pop on handshake.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("count", count, sb.size());
                chk("rd_valid", rd_valid, sb.size() != 0);
                if (sb.size() != 0) chk("rd_data", rd_data, sb[0]);
                else                chk("rd_data_empty", rd_data, 0);
                chk("overflow", overflow, m_ovf);
                chk("period_flag", period_flag, p_flag);
                chk("period_len", period_len, p_len);
                chk("count3", count3, q3.size());
                if (q3.size() != 0) chk("rd_data3", rd_data3, q3[0]);
                chk("overflow3", overflow3, m_ovf3);
                if (rd_valid && rd_ready && sb.size() != 0) void'(sb.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : stim
        int guard;
        #1;
        chk("rst_count", count, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_period_flag", period_flag, 0);
        chk("rst_period_len", period_len, 0);
        #1 reset = 1'b0;

        // Fill: 2 setup edges then 8 pushes.
        en = 1; rd_ready = 0;
        step(10);
        chk("fill_count", count, 8);
        chk("fill_overflow", overflow, 0);
        chk("fill_count3", count3, 2);

        // Drain in order with sampling stopped.
        en = 0; rd_ready = 1;
        step(9);
        chk("drain_rd_valid", rd_valid, 0);

        // Refill, then run full with continuous pops.
        en = 1; rd_ready = 0;
        step(10);
        rd_ready = 1;
        step(10);
        chk("fullpop_count", count, 8);
        chk("fullpop_overflow", overflow, 0);

        // One sample into a full FIFO with no pop is dropped.
        rd_ready = 0;
        step(1);
        chk("ovf_flag", overflow, 1);
        chk("ovf_count", count, 8);

        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            rd_ready = $urandom_range(0, 1);
            step(1);
        end

        // Mid-fill reset with five entries buffered.
        en = 0; rd_ready = 1;
        step(9);
        en = 1; rd_ready = 0;
        guard = 0;
        while (sb.size() != 5 && guard < 20) begin
            step(1);
            guard++;
        end
        chk("midfill_reached", sb.size(), 5);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_rd_valid", rd_valid, 0);
        chk("mid_rst_rd_data", rd_data, 0);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_period_flag", period_flag, 0);
        chk("mid_rst_count3", count3, 0);
        #3 reset = 1'b0;

        // From reset: decimation by 3 and a full LFSR period.
        en = 1; rd_ready = 1;
        step(11);
        chk("decim3_count", count3, 3);
        step(9);
`ifdef RNG_PERIOD_DETECT_EN
        chk("period_flag_end", period_flag, 1);
        chk("period_len_end", period_len, 15);
`else
        chk("period_flag_end", period_flag, 0);
        chk("period_len_end", period_len, 0);
`endif
        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rng_sample_fifo.md
RNG_SAMPLE_FIFO -- requirements
Module: rng_sample_fifo

Interface
REQ-001 Parameter: WIDTH, 32, width of the random word taken from the RNG/LFSR stage.
REQ-002 Parameter: DEPTH, 8, number of FIFO entries; SHALL be a power of 2 and at least 2.
REQ-003 Parameter: DECIM, 1, keep one sample in every DECIM cycles; range 1..255.
REQ-004 Port: clk, input, 1, single clock; all logic is on the rising edge.
REQ-005 Port: reset, input, 1, asynchronous active-high reset.
REQ-006 Port: en, input, 1, enables sampling.
REQ-007 Port: lfsr_q, input, WIDTH, free-running random word from the upstream LFSR; a new value arrives every cycle.
REQ-008 Port: rd_valid, output, 1, head entry is available.
REQ-009 Port: rd_ready, input, 1, consumer accepts the head entry.
REQ-010 Port: rd_data, output, WIDTH, head entry.
REQ-011 Port: count, output, $clog2(DEPTH)+1, current occupancy.
REQ-012 Port: overflow, output, 1, sticky flag: a sample was dropped.
REQ-013 Port: period_flag, output, 1, sticky flag: the LFSR sequence has wrapped.
REQ-014 Port: period_len, output, 32, number of samples counted until the wrap.

Function
REQ-015 Sampler FSM states and transitions:
- IDLE -> ARM when en=1.
- ARM -> RUN after one cycle; the sample present in ARM is discarded because it is the LFSR reset value.
- Any state -> IDLE when en=0.
REQ-016 Decimation counter:
- In RUN, the counter counts 0..DECIM-1 and wraps to 0.
- A push is requested when the counter equals DECIM-1.
- Entering RUN loads the counter with 0.
REQ-017 Push stores lfsr_q as sampled on the same edge.
REQ-018 A pop occurs when rd_valid=1 and rd_ready=1 on a rising edge.
REQ-019 rd_valid = (count != 0).
REQ-020 rd_data SHALL show the head entry combinationally from storage; there is no fall-through. A push into an empty FIFO gives rd_valid=1 on the next cycle.
REQ-021 Push while full:
- If a pop occurs in the same cycle, the push SHALL be accepted and count is unchanged.
- Otherwise the sample is dropped and overflow is set to 1.
REQ-022 Pop with no concurrent push decrements count. Simultaneous push and pop while not full leaves count unchanged.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH. count SHALL never exceed DEPTH or go below 0.
REQ-024 A pop while empty SHALL be ignored; rd_ready is don't-care when rd_valid=0.
REQ-025 en=0 stops pushes only. Buffered entries remain readable and the flags hold their values.

Reset
REQ-026 Reset SHALL be asserted asynchronously. Release is synchronous to clk, and the first active edge is the first one after reset falls.
REQ-027 Values while in reset:
- FSM = IDLE.
- Pointers = 0, count = 0, rd_valid = 0, rd_data = 0.
- overflow = 0, period_flag = 0, period_len = 0.
- Decimation counter = 0.
REQ-028 Reset mid-operation SHALL discard all buffered entries. FIFO storage contents need not be cleared, but rd_data SHALL read 0 while count=0.

Configuration
REQ-029 Macro: RNG_PERIOD_DETECT_EN.
REQ-030 Behaviour when RNG_PERIOD_DETECT_EN is defined:
- The first sample pushed after reset is latched as the reference value.
- A 32-bit counter counts every push request, including dropped ones.
- When a later push request matches the reference, period_flag is set to 1 and period_len is frozen at the count; period_len counts pushes after the reference, including the matching one.
- The counter saturates at 2^32-1.
REQ-031 Behaviour when RNG_PERIOD_DETECT_EN is undefined: no reference register and no counter are built; period_flag and period_len are tied to 0.

Structure
REQ-032 Shared package rng_pkg SHALL hold:
- the sampler state encoding (IDLE=2'd0, ARM=2'd1, RUN=2'd2);
- the default parameter constants RNG_WIDTH=32 and RNG_FIFO_DEPTH=8.
REQ-033 Sub-module rng_sync_fifo SHALL contain the storage, pointers, count and handshake. rng_sample_fifo SHALL contain the FSM, decimation and period logic.

Verification
REQ-034 Fill and drain: reset for 2 ns, en=1, DECIM=1, rd_ready=0, 4-bit LFSR seed 1. The first sample is discarded. After 8 pushes, count=8. With rd_ready=1, 8 pops return the LFSR sequence in order, and rd_valid falls after the 8th.
REQ-035 Overflow: FIFO full, rd_ready=0, one more sample -> overflow=1, count stays 8, and the head entry is unchanged.
REQ-036 Full with pop: FIFO full, rd_ready=1 continuously -> one push and one pop per cycle, count=8, overflow stays 0.
REQ-037 Decimation: DECIM=3 -> only every 3rd lfsr_q value is stored, so 9 RUN cycles produce count=3.
REQ-038 Period detection (macro defined): 4-bit maximal LFSR -> period_flag=1 with period_len=15. Macro undefined -> period_flag=0 throughout.
REQ-039 Reset mid-fill: assert reset with count=5 -> count=0, rd_valid=0 and flags=0 immediately, without waiting for a clock edge.
